// File: rtl/dir_step_ctrl_if.sv
// Button-to-counter handshake bundle for dir_step_ctrl: raw buttons in,
// direction level, step pulse and debounced levels out.
interface dir_step_ctrl_if;
    logic       btn_up;
    logic       btn_dn;
    logic       up;
    logic       step;
    logic [1:0] held;

    modport master (output btn_up, btn_dn, input up, step, held);
    modport slave  (input btn_up, btn_dn, output up, step, held);
endinterface

// File: rtl/dir_step_ctrl.sv
// Synchronize and debounce the up/down buttons, emit a direction level and a
// one-cycle step per press. Define AUTOREPEAT_EN to add hold-to-repeat steps.
module dir_step_ctrl #(
    parameter int DEB_CYCLES    = 4,
    parameter int CNT_W         = 8,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dir_step_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_e;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (($clog2(DEB_CYCLES + 1) > CNT_W) || ($clog2(REPEAT_CYCLES + 1) > CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEB_CYCLES/REPEAT_CYCLES");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // Index 0 is the up button, index 1 the down button, matching held = {dn, up}.
    logic [1:0]       sync1_q, sync2_q;
    state_e           state_q [2];
    state_e           state_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press_ev;
    logic [1:0]       step_ev;
    logic [1:0]       held_q, held_d;
    logic             up_q, up_d;
    logic             step_q, step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {bus.btn_dn, bus.btn_up};
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            held_q <= 2'b00;
            up_q   <= 1'b1;
            step_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            held_q <= held_d;
            up_q   <= up_d;
            step_q <= step_d;
        end
    end

    always_comb begin
        press_ev = 2'b00;
        held_d   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ARMING;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                ARMING: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i]  = PRESSED;
                        cnt_d[i]    = '0;
                        press_ev[i] = 1'b1;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = RELEASING;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                RELEASING: begin
                    // A high sample here is a release glitch: back to PRESSED silently.
                    if (sync2_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            held_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASING);
        end
    end

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rpt_q [2];
    logic [CNT_W-1:0] rpt_d [2];
    logic [1:0]       rpt_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) rpt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) rpt_q[i] <= rpt_d[i];
        end
    end

    // Counter only runs while staying in PRESSED; any other path clears it.
    always_comb begin
        rpt_ev = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rpt_d[i] = '0;
            if ((state_q[i] == PRESSED) && sync2_q[i]) begin
                if (rpt_q[i] == RPT_LAST) begin
                    rpt_ev[i] = 1'b1;
                end else begin
                    rpt_d[i] = sat_inc(rpt_q[i]);
                end
            end
        end
    end

    assign step_ev = press_ev | rpt_ev;
`else
    assign step_ev = press_ev;
`endif

    // Simultaneous up and down events step once and keep the old direction.
    always_comb begin
        step_d = |step_ev;
        up_d   = up_q;
        if (step_ev == 2'b01) begin
            up_d = 1'b1;
        end else if (step_ev == 2'b10) begin
            up_d = 1'b0;
        end
    end

    assign bus.up   = up_q;
    assign bus.step = step_q;
    assign bus.held = held_q;
endmodule

// File: tb/tb_dir_step_ctrl.sv
// Self-checking bench for dir_step_ctrl: table of button presses plus bounce
// and mid-debounce reset sequences, step pulses checked against a scoreboard.
module tb_dir_step_ctrl;
    localparam int DEB = 4;
    localparam int RPT = 8;

    typedef struct {
        logic       bu;
        logic       bd;
        int         hold;
        int         gap;
        logic       exp_step;
        logic [1:0] exp_held;
        logic       exp_up;
    } vec_t;

    typedef struct {
        int   edge_n;
        logic up;
    } sb_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errs;
    sb_t  sbq [$];
    vec_t vecs [9];

    dir_step_ctrl_if bus ();

    dir_step_ctrl #(
        .DEB_CYCLES   (DEB),
        .CNT_W        (8),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_step(input int e, input logic u);
        sb_t s;
        s.edge_n = e;
        s.up     = u;
        sbq.push_back(s);
    endtask

    // Step monitor: every step must match the oldest expected one, in cycle and direction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.step === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errs++;
                    $display("FAIL step_unexpected: step=1 at cycle %0d, none expected", cyc);
                end else begin
                    sb_t s;
                    s = sbq.pop_front();
                    if (s.edge_n != cyc || bus.up !== s.up) begin
                        errs++;
                        $display("FAIL step_match: cycle %0d up=%b, expected cycle %0d up=%b",
                                 cyc, bus.up, s.edge_n, s.up);
                    end
                end
            end else if (sbq.size() != 0 && sbq[0].edge_n < cyc) begin
                sb_t s;
                s = sbq.pop_front();
                checks++;
                errs++;
                $display("FAIL step_missing: no step at cycle %0d, expected up=%b", s.edge_n, s.up);
            end
        end
    end

    // Drive one press record; buttons change at a negedge, first sampled edge is k+1.
    task automatic apply_vec(input vec_t v, input int idx);
        int k;
        @(negedge clk);
        bus.btn_up = v.bu;
        bus.btn_dn = v.bd;
        k = cyc;
        if (v.exp_step) begin
            push_step(k + DEB + 2, v.exp_up);
`ifdef AUTOREPEAT_EN
            for (int e = k + DEB + 2 + RPT; e <= k + v.hold + 2; e += RPT) push_step(e, v.exp_up);
`endif
        end
        for (int t = 1; t <= v.hold + v.gap; t++) begin
            @(negedge clk);
            if (t == v.hold) begin
                bus.btn_up = 1'b0;
                bus.btn_dn = 1'b0;
            end
            if (t == DEB + 1) chk($sformatf("vec%0d_held_before", idx), bus.held, 0);
            if (t == DEB + 2) chk($sformatf("vec%0d_held_accept", idx), bus.held, v.exp_held);
        end
        chk($sformatf("vec%0d_up_after", idx), bus.up, v.exp_up);
        chk($sformatf("vec%0d_held_after", idx), bus.held, 0);
    endtask

    initial begin
        int   k;
        vec_t v;
        checks = 0;
        errs   = 0;

        vecs[0] = '{1'b1, 1'b0, 20, 12, 1'b1, 2'b01, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 10, 12, 1'b1, 2'b10, 1'b0};
        vecs[2] = '{1'b1, 1'b0,  3, 12, 1'b0, 2'b00, 1'b0};
        vecs[3] = '{1'b1, 1'b0,  8, 12, 1'b1, 2'b01, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 10, 12, 1'b1, 2'b11, 1'b1};
        vecs[5] = '{1'b0, 1'b1,  4, 12, 1'b1, 2'b10, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 10, 12, 1'b1, 2'b11, 1'b0};
        vecs[7] = '{1'b0, 1'b1,  1, 12, 1'b0, 2'b00, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 45, 12, 1'b1, 2'b10, 1'b0};

        rst_n      = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {bus.up, bus.step, bus.held}, 4'b1000);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_outputs", {bus.up, bus.step, bus.held}, 4'b1000);
        end

        for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

        // Reset pulse while the up button is mid-ARMING, with up=0 beforehand.
        @(negedge clk);
        bus.btn_up = 1'b1;
        k = cyc;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midarm_reset_outputs", {bus.up, bus.step, bus.held}, 4'b1000);
        push_step(k + 10, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midarm_held_accept", bus.held, 2'b01);
        repeat (2) @(negedge clk);
        bus.btn_up = 1'b0;
        repeat (12) @(negedge clk);
        chk("midarm_up_after", bus.up, 1);
        chk("midarm_held_after", bus.held, 0);

        // Down button bounces 1,0,1,0 then stays high.
        @(negedge clk);
        bus.btn_dn = 1'b1;
        k = cyc;
        @(negedge clk); bus.btn_dn = 1'b0;
        @(negedge clk); bus.btn_dn = 1'b1;
        @(negedge clk); bus.btn_dn = 1'b0;
        @(negedge clk); bus.btn_dn = 1'b1;
        push_step(k + 10, 1'b0);
        repeat (5) @(negedge clk);
        chk("bounce_held_before", bus.held, 0);
        @(negedge clk);
        chk("bounce_held_accept", bus.held, 2'b10);
        repeat (2) @(negedge clk);
        bus.btn_dn = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_up_after", bus.up, 0);
        chk("bounce_held_after", bus.held, 0);
        v = '{1'b1, 1'b0, 8, 12, 1'b1, 2'b01, 1'b1};
        apply_vec(v, 9);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
